// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues word fetches, buffers {pc,instr} in a 2-entry queue for ID.
// Latency: fetched word visible on IF_* the cycle after IMEM_VALID; next request the cycle after VALID.
// Backpressure: STALL holds the queue head; no request issues unless queued + outstanding leaves a free slot.
// Ports: CLK/RESET (async active-low); IMEM_REQ/ADDR/READY/VALID/RDATA memory side;
//        BRANCH_TAKEN/BRANCH_TARGET redirect from EX; STALL from ID;
//        PC (next fetch address), IF_PC/IF_INSTR/IF_VALID queue head toward ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_READY,
  input  logic        IMEM_VALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        STALL,
  output logic [31:0] PC,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_INSTR,
  output logic        IF_VALID
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q;
  logic [31:0] fetch_addr_q;   // address of the request currently in flight
  logic [31:0] q_pc    [2];
  logic [31:0] q_instr [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic [31:0] hold_pc;        // last head PC, shown on IF_PC while the queue is empty
  logic        req, accept, push, pop, q_empty;

  // Redirect targets are always word aligned; the two low bits are dropped on purpose.
  logic        tgt_low_unused;
  assign tgt_low_unused = ^BRANCH_TARGET[1:0];

  assign q_empty   = (count == 2'd0);
  assign IF_VALID  = !q_empty && !BRANCH_TAKEN;
  assign IF_PC     = q_empty ? hold_pc : q_pc[rd_ptr];
  assign IF_INSTR  = IF_VALID ? q_instr[rd_ptr] : NOP_INSTR;
  assign pop       = IF_VALID && !STALL;
  assign PC        = pc_q;
  assign IMEM_ADDR = pc_q;
  assign IMEM_REQ  = req;
  assign accept    = req && IMEM_READY;

  // Next state, request and push decisions. Only IDLE can have nothing in flight,
  // so "count < 2" there is the full entries+outstanding reservation rule.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        // RESET gating keeps the request low while reset is held.
        req = RESET && !BRANCH_TAKEN && (count < 2'd2);
        if (req && IMEM_READY) state_nxt = WAIT;
      end
      WAIT: begin
        if (IMEM_VALID) begin
          push      = !BRANCH_TAKEN;
          state_nxt = IDLE;
        end else if (BRANCH_TAKEN) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (IMEM_VALID) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q         <= RESET_PC;
      fetch_addr_q <= 32'h0;
    end else begin
      if (accept) fetch_addr_q <= pc_q;
      if (BRANCH_TAKEN)  pc_q <= {BRANCH_TARGET[31:2], 2'b00};
      else if (accept)   pc_q <= pc_q + 32'd4;
    end
  end

  // Queue control. A redirect flushes everything and suppresses push/pop that cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      hold_pc <= 32'h0;
    end else begin
      if (!q_empty) hold_pc <= q_pc[rd_ptr];
      if (BRANCH_TAKEN) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: entries are only read once count says they were written.
  always_ff @(posedge CLK) begin
    if (push && !BRANCH_TAKEN) begin
      q_pc[wr_ptr]    <= fetch_addr_q;
      q_instr[wr_ptr] <= IMEM_RDATA;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit with a transaction-level reference model.
// Inputs are driven 1 time unit after the rising edge; all checks run on the falling edge.
// A memory responder with random latency answers accepted fetches.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READY;
  logic        IMEM_VALID;
  logic [31:0] IMEM_RDATA;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        STALL;
  logic [31:0] PC;
  logic [31:0] IF_PC;
  logic [31:0] IF_INSTR;
  logic        IF_VALID;

  if_fetch_unit dut (
    .CLK(CLK), .RESET(RESET),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_READY(IMEM_READY),
    .IMEM_VALID(IMEM_VALID), .IMEM_RDATA(IMEM_RDATA),
    .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET), .STALL(STALL),
    .PC(PC), .IF_PC(IF_PC), .IF_INSTR(IF_INSTR), .IF_VALID(IF_VALID)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference model state
  ent_t        exp_q[$];      // words fetched and not yet consumed by ID, in program order
  logic [31:0] fetch_pc;      // next address the fetch stream must request
  bit          mem_busy;      // a fetch is outstanding in the memory
  bit          mem_drop;      // the outstanding fetch was overtaken by a redirect
  logic [31:0] mem_addr;
  int          mem_lat;
  bit          mon_en;
  int          n_checks;
  int          n_fail;
  int          pops;
  bit          wrap_seen;
  logic [31:0] last_pop_pc;

  // Stimulus knobs
  int ready_pct, stall_pct, br_pm, lat_min, lat_max;
  bit br_on_valid, prev_br;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  function automatic logic [31:0] rand_target();
    if ($urandom_range(9) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(15));
    return 32'($urandom_range(32'h3FF));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: compare first against the model as it stands, then advance it.
  always @(negedge CLK) begin
    if (RESET && mon_en) begin
      bit busy0;
      busy0 = mem_busy;
      chk("pc_reg", PC, fetch_pc);
      chk("imem_req", IMEM_REQ, (!busy0 && exp_q.size() < 2 && !BRANCH_TAKEN));
      if (IMEM_REQ) chk("imem_addr", IMEM_ADDR, fetch_pc);
      chk("if_valid", IF_VALID, (exp_q.size() != 0 && !BRANCH_TAKEN));
      if (!IF_VALID) chk("nop_instr", IF_INSTR, NOP);
      if (IF_VALID && !STALL && exp_q.size() != 0) begin
        ent_t e;
        e = exp_q.pop_front();
        chk("pop_pc", IF_PC, e.pc);
        chk("pop_instr", IF_INSTR, e.instr);
        if (last_pop_pc == 32'hFFFF_FFFC && e.pc == 32'h0) wrap_seen = 1'b1;
        last_pop_pc = e.pc;
        pops++;
      end
      if (BRANCH_TAKEN) begin
        exp_q.delete();
        fetch_pc = BRANCH_TARGET & 32'hFFFF_FFFC;
        if (mem_busy && !IMEM_VALID) mem_drop = 1'b1;
      end
      if (IMEM_VALID && mem_busy) begin
        if (!BRANCH_TAKEN && !mem_drop) exp_q.push_back({mem_addr, word_of(mem_addr)});
        mem_busy = 1'b0;
      end
      if (IMEM_REQ && IMEM_READY) begin
        chk("one_outstanding", 32'(busy0), 32'h0);
        mem_busy = 1'b1;
        mem_drop = 1'b0;
        mem_addr = IMEM_ADDR;
        mem_lat  = $urandom_range(lat_max, lat_min);
        fetch_pc = fetch_pc + 32'd4;
      end
      if (exp_q.size() > 2) begin
        chk("queue_overflow", 32'(exp_q.size()), 32'd2);
        exp_q.pop_front();
      end
    end
  end

  // One clock of stimulus: memory response, handshake inputs and an optional redirect.
  task automatic cycle(input bit br_force, input logic [31:0] br_tgt);
    @(posedge CLK); #1;
    IMEM_VALID = 1'b0;
    IMEM_RDATA = $urandom;
    if (mem_busy) begin
      if (mem_lat <= 1) begin
        IMEM_VALID = 1'b1;
        IMEM_RDATA = word_of(mem_addr);
      end else begin
        mem_lat--;
      end
    end
    IMEM_READY    = ($urandom_range(99) < ready_pct);
    STALL         = ($urandom_range(99) < stall_pct);
    BRANCH_TAKEN  = 1'b0;
    BRANCH_TARGET = $urandom;
    if (!prev_br) begin
      if (br_force) begin
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = br_tgt;
      end else if ((br_on_valid && IMEM_VALID) || ($urandom_range(999) < br_pm)) begin
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = rand_target();
      end
    end
    prev_br = BRANCH_TAKEN;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
  endtask

  task automatic set_knobs(input int rdy, input int stl, input int br, input int lmin, input int lmax);
    ready_pct = rdy; stall_pct = stl; br_pm = br; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic reset_model();
    exp_q.delete();
    fetch_pc    = 32'h0;
    mem_busy    = 1'b0;
    mem_drop    = 1'b0;
    last_pop_pc = 32'h1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},      IMEM_REQ, 32'h0);
    chk({tag, "_if_valid"}, IF_VALID, 32'h0);
    chk({tag, "_if_pc"},    IF_PC,    32'h0);
    chk({tag, "_if_instr"}, IF_INSTR, NOP);
    chk({tag, "_pc"},       PC,       32'h0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; pops = 0; wrap_seen = 1'b0;
    mon_en = 1'b0; prev_br = 1'b0; br_on_valid = 1'b0; mem_lat = 0;
    RESET = 1'b0; IMEM_READY = 1'b0; IMEM_VALID = 1'b0; IMEM_RDATA = 32'h0;
    BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0; STALL = 1'b0;
    reset_model();
    set_knobs(100, 0, 0, 1, 1);

    repeat (3) @(posedge CLK);
    #1 check_reset_outputs("reset");

    @(posedge CLK); #1;
    RESET = 1'b1; IMEM_READY = 1'b1; mon_en = 1'b1;

    // Back-to-back fetch with single-cycle memory
    run(20);
    // Slow READY: request must hold address until accepted
    set_knobs(25, 0, 0, 1, 2);
    run(60);
    // ID stalled: queue fills to two and requests stop, then drains in order
    set_knobs(100, 100, 0, 1, 1);
    run(15);
    set_knobs(100, 0, 0, 1, 1);
    run(15);
    // Mixed random traffic with redirects
    set_knobs(80, 30, 60, 1, 3);
    run(1500);
    // Redirects landing on the same cycle as a memory response
    br_on_valid = 1'b1;
    set_knobs(90, 20, 0, 1, 2);
    run(300);
    br_on_valid = 1'b0;

    // PC wrap through the top of the address space (low target bits must be ignored)
    set_knobs(100, 0, 0, 1, 1);
    run(3);
    cycle(1'b1, 32'hFFFF_FFF7);
    run(20);
    chk("pc_wrap_seen", 32'(wrap_seen), 32'h1);

    // Reset asserted while a fetch is in flight
    set_knobs(100, 0, 0, 3, 3);
    begin
      int n = 0;
      while (!mem_busy && n < 50) begin cycle(1'b0, 32'h0); n++; end
      chk("reset_wait_reached", 32'(mem_busy), 32'h1);
    end
    @(posedge CLK); #1;
    RESET = 1'b0; mon_en = 1'b0; IMEM_VALID = 1'b0; BRANCH_TAKEN = 1'b0; prev_br = 1'b0;
    #1 check_reset_outputs("midreset");
    reset_model();
    repeat (2) @(posedge CLK);
    #1;
    // Release with a stray response that no request asked for
    RESET = 1'b1; IMEM_VALID = 1'b1; IMEM_RDATA = 32'hDEAD_BEEF; IMEM_READY = 1'b0;
    STALL = 1'b0; mon_en = 1'b1;
    set_knobs(80, 20, 0, 1, 2);
    run(60);
    set_knobs(80, 20, 30, 1, 3);
    run(400);

    chk("progress", 32'(pops > 300), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
